// File: rtl/chess_pkg.sv
// chess_pkg -- shared definitions for the move-commit block.
//   Piece-type codes, the colour bit position inside a 4-bit square code,
//   the promotion rows for each colour, the move FSM state encoding and a
//   helper that extracts one square from the packed 256-bit board.
//   Optional feature elsewhere: MOVE_COMMIT_PROMOTION_EN.
package chess_pkg;

    // Low three bits of a square code. A whole code of 0 means an empty square.
    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } pieceType_e;

    // Bit 3 of a square code holds the colour: 0 white, 1 black.
    localparam int COLOUR_BIT = 3;
    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    // Board geometry. A square index is column-major, so the row is index[2:0].
    localparam int SQ_BITS    = 4;
    localparam int BOARD_BITS = 64 * SQ_BITS;

    // Row a pawn of each colour must reach to promote.
    localparam logic [2:0] WHITE_PROMO_ROW = 3'd0;
    localparam logic [2:0] BLACK_PROMO_ROW = 3'd7;

    typedef enum logic [1:0] {
        SEL_SRC = 2'd0,
        SEL_DST = 2'd1,
        CHECK   = 2'd2,
        APPLY   = 2'd3
    } moveState_e;

    // Return the 4-bit code of square idx; square n is at bits [4n+3:4n].
    function automatic logic [SQ_BITS-1:0] squareAt(
        input logic [BOARD_BITS-1:0] brd,
        input logic [5:0]            idx
    );
        return brd[{idx, 2'b00} +: SQ_BITS];
    endfunction

endpackage

// File: rtl/board_write.sv
// board_write -- next-board calculator for a single committed move.
//   Purely combinational: copies the source square into the destination,
//   empties the source and leaves every other square untouched. A capture is
//   just an overwrite of the destination square.
// Ports:
//   board      in  256  current board contents
//   src        in  6    source square index
//   dst        in  6    destination square index (never equal to src)
//   promote    in  1    write the moved piece as a queen of its own colour
//   boardNext  out 256  board after the move
module board_write
    import chess_pkg::*;
(
    input  logic [BOARD_BITS-1:0] board,
    input  logic [5:0]            src,
    input  logic [5:0]            dst,
    input  logic                  promote,
    output logic [BOARD_BITS-1:0] boardNext
);

    logic [SQ_BITS-1:0] piece;

    // NOTE: always_comb uses blocking assignments, so each later write below
    // overrides the earlier one within the same evaluation.
    always_comb begin
        piece = squareAt(board, src);
        if (promote) begin
            piece = {piece[COLOUR_BIT], QUEEN};
        end
        boardNext                         = board;
        boardNext[{src, 2'b00} +: SQ_BITS] = '0;
        boardNext[{dst, 2'b00} +: SQ_BITS] = piece;
    end

endmodule

// File: rtl/move_commit.sv
// move_commit -- source/destination selection and move commit for a chess board.
//   The player picks a square of their own colour, then a target square. The
//   move is presented on move_data for CHECK_LAT cycles, the external checker's
//   verdict on allow_move is sampled, and a legal move is written to the board
//   in a single APPLY cycle, after which the side to move toggles.
//   Build option: define MOVE_COMMIT_PROMOTION_EN to turn a pawn reaching the
//   last row (row 0 for white, row 7 for black) into a queen of its colour.
// Parameters:
//   CHECK_LAT    cycles move_data is held before allow_move is sampled (1..15)
//   START_BOARD  board contents after reset
// Ports:
//   clk         in  1    clock, rising edge
//   rst_n       in  1    asynchronous active-low reset
//   cursor      in  6    square under the cursor
//   select      in  1    one-cycle select pulse
//   cancel      in  1    abandon the current selection (beats select)
//   allow_move  in  1    legality verdict for move_data
//   move_data   out 14   {1'b0, turn, src, dst} for the move checker
//   board       out 256  board contents, square n at [4n+3:4n]
//   turn        out 1    side to move, 0 white
//   busy        out 1    high while checking or applying a move
//   commit      out 1    one-cycle pulse after a move is written
//   reject      out 1    one-cycle pulse after a selection or move is refused
module move_commit
    import chess_pkg::*;
#(
    parameter int                    CHECK_LAT   = 2,
    parameter logic [BOARD_BITS-1:0] START_BOARD = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            cursor,
    input  logic                  select,
    input  logic                  cancel,
    input  logic                  allow_move,
    output logic [13:0]           move_data,
    output logic [BOARD_BITS-1:0] board,
    output logic                  turn,
    output logic                  busy,
    output logic                  commit,
    output logic                  reject
);

    // Counter value during the cycle in which allow_move is sampled.
    localparam logic [3:0] LAST_WAIT = 4'(CHECK_LAT - 1);

    moveState_e            state, stateNext;
    logic [5:0]            src, srcNext;
    logic [5:0]            dst, dstNext;
    logic [3:0]            waitCnt, waitCntNext;
    logic                  turnNext;
    logic                  commitNext, rejectNext;
    logic [BOARD_BITS-1:0] boardNext;
    logic [BOARD_BITS-1:0] boardMoved;
    logic [SQ_BITS-1:0]    cursorPiece;
    logic                  cursorIsOwn;
    logic                  promote;

    assign cursorPiece = squareAt(board, cursor);
    assign cursorIsOwn = (cursorPiece != '0) && (cursorPiece[COLOUR_BIT] == turn);

`ifdef MOVE_COMMIT_PROMOTION_EN
    logic [SQ_BITS-1:0] movingPiece;
    logic               onLastRow;

    assign movingPiece = squareAt(board, src);
    assign onLastRow   = (movingPiece[COLOUR_BIT] == WHITE) ? (dst[2:0] == WHITE_PROMO_ROW)
                                                            : (dst[2:0] == BLACK_PROMO_ROW);
    assign promote     = (movingPiece[2:0] == PAWN) && onLastRow;
`else
    assign promote = 1'b0;
`endif

    board_write u_boardWrite (
        .board     (board),
        .src       (src),
        .dst       (dst),
        .promote   (promote),
        .boardNext (boardMoved)
    );

    // src, dst and turn only change outside CHECK/APPLY, so the checker sees a
    // stable request for the whole evaluation.
    assign move_data = {1'b0, turn, src, dst};
    assign busy      = (state == CHECK) || (state == APPLY);

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        stateNext   = state;
        srcNext     = src;
        dstNext     = dst;
        waitCntNext = waitCnt;
        turnNext    = turn;
        boardNext   = board;
        commitNext  = 1'b0;
        rejectNext  = 1'b0;

        case (state)
            SEL_SRC: begin
                if (select) begin
                    if (cursorIsOwn) begin
                        srcNext   = cursor;
                        stateNext = SEL_DST;
                    end else begin
                        rejectNext = 1'b1;
                    end
                end
            end

            SEL_DST: begin
                if (cancel) begin
                    stateNext = SEL_SRC;
                end else if (select) begin
                    if (cursor == src) begin
                        // Clicking the source again just deselects it.
                        stateNext = SEL_SRC;
                    end else begin
                        dstNext     = cursor;
                        waitCntNext = '0;
                        stateNext   = CHECK;
                    end
                end
            end

            CHECK: begin
                waitCntNext = waitCnt + 4'd1;
                if (waitCnt == LAST_WAIT) begin
                    if (allow_move) begin
                        stateNext = APPLY;
                    end else begin
                        rejectNext = 1'b1;
                        stateNext  = SEL_SRC;
                    end
                end
            end

            APPLY: begin
                boardNext  = boardMoved;
                turnNext   = ~turn;
                commitNext = 1'b1;
                stateNext  = SEL_SRC;
            end

            default: stateNext = SEL_SRC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEL_SRC;
            src     <= '0;
            dst     <= '0;
            waitCnt <= '0;
            turn    <= WHITE;
            // NOTE: the board is architectural state, not scratch storage, so
            // it is reset to the starting position like any other register.
            board   <= START_BOARD;
            commit  <= 1'b0;
            reject  <= 1'b0;
        end else begin
            state   <= stateNext;
            src     <= srcNext;
            dst     <= dstNext;
            waitCnt <= waitCntNext;
            turn    <= turnNext;
            board   <= boardNext;
            commit  <= commitNext;
            reject  <= rejectNext;
        end
    end

endmodule

// File: doc/move_commit.md
MOVE_COMMIT -- requirements
Module: move_commit

Interface
REQ-001 Parameter CHECK_LAT, default 2: cycles move_data is held before allow_move is sampled (legal range 1..15).
REQ-002 Parameter START_BOARD, default 256'h0: board contents after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cursor  input  6  square index under the cursor (0..63, column-major: row = index[2:0], column = index[5:3]).
REQ-006 select  input  1  one-cycle pulse: player pressed select.
REQ-007 cancel  input  1  level/pulse: abandon the current selection.
REQ-008 allow_move  input  1  legality verdict from the move checker for move_data.
REQ-009 move_data  output  14  {1'b0, turn, src[5:0], dst[5:0]} presented to the move checker.
REQ-010 board  output  256  square n at board[4n+3:4n]; code 0 = empty, bit3 = colour (0 white, 1 black), bits2:0 = piece type.
REQ-011 turn  output  1  side to move (0 white).
REQ-012 busy  output  1  high in CHECK and APPLY.
REQ-013 commit  output  1  one-cycle pulse when a move is written to board.
REQ-014 reject  output  1  one-cycle pulse when a selection or move is refused.

Function
REQ-015 FSM states SEL_SRC, SEL_DST, CHECK, APPLY; reset state SEL_SRC.
REQ-016 SEL_SRC: select with board[cursor] nonzero and its bit3 == turn SHALL latch src = cursor and go to SEL_DST; select on an empty or opponent square SHALL pulse reject and stay.
REQ-017 SEL_DST: cancel SHALL return to SEL_SRC (cancel wins over a simultaneous select); select with cursor == src SHALL deselect and return to SEL_SRC without reject; any other select SHALL latch dst = cursor, clear the wait counter, go to CHECK.
REQ-018 CHECK: the 4-bit wait counter SHALL increment each cycle; allow_move SHALL be sampled in the cycle the counter equals CHECK_LAT-1 (first sample CHECK_LAT cycles after entering CHECK); 1 -> APPLY, 0 -> reject pulse and SEL_SRC.
REQ-019 APPLY (exactly one cycle): board[dst] <= board[src], board[src] <= 0, turn toggles, commit pulses next cycle-edge, return to SEL_SRC.
REQ-020 select and cancel SHALL be ignored in CHECK and APPLY.
REQ-021 move_data SHALL be combinationally {1'b0, turn, src, dst} from the latched registers and SHALL NOT change from entry to CHECK until APPLY completes.
REQ-022 Capturing an opponent piece is a plain overwrite of board[dst]; no other square changes.
REQ-023 commit and reject SHALL never assert in the same cycle; each is high for exactly one cycle.

Reset
REQ-024 On rst_n low: state SEL_SRC, board = START_BOARD, turn = 0, src = dst = 0, counter = 0, commit = reject = 0, busy = 0; move_data = 14'h0.
REQ-025 Reset asserted mid-CHECK or mid-APPLY SHALL abort with no board change.

Configuration
REQ-026 Macro MOVE_COMMIT_PROMOTION_EN defined: in APPLY, a pawn (type 1) landing on row 0 (white) or row 7 (black) SHALL be written as queen (type 5) of the same colour.
REQ-027 Macro undefined: the piece is copied unchanged; no promotion logic is synthesised.

Structure
REQ-028 Shared package chess_pkg holds piece-type constants (EMPTY 0, PAWN 1, KNIGHT 2, BISHOP 3, ROOK 4, QUEEN 5, KING 6), colour bit position, and FSM state encoding.
REQ-029 One sub-module board_write: given board, src, dst and promote flag, produces the next 256-bit board combinationally.

Verification
REQ-030 START_BOARD has white pawn (4'h1) at 9; select 9, select 10, allow_move=1 -> after CHECK_LAT+1 cycles commit, board[10]=1, board[9]=0, turn=1.
REQ-031 turn=0, select on square holding 4'h9 (black pawn) -> reject pulse, state stays SEL_SRC, board unchanged.
REQ-032 select src, select dst, allow_move=0 -> reject pulse, board and turn unchanged, next select treated as source.
REQ-033 select src, then select and cancel in the same cycle -> back to SEL_SRC, no reject, no commit.
REQ-034 Pulse select during CHECK with a different cursor -> ignored; move_data unchanged through APPLY.
REQ-035 With MOVE_COMMIT_PROMOTION_EN, white pawn 1->0 allowed -> board[0]=4'h5; without macro -> board[0]=4'h1.
